ib_lut_page_loader: RTL



---
 rtl/ib_lut_page_loader.sv | 115 +++++++++++
 1 files changed

// File: rtl/ib_lut_page_loader.sv
// Ping-pong LUT page loader: streams the next iteration's LUT pages into the
// shadow frame of the IB-CNU RAM, then swaps the active read frame.
module ib_lut_page_loader #(
   parameter int ENTRY_ADDR      = 4,
   parameter int MULTI_FRAME_NUM = 2,
   parameter int BANK_NUM        = 2,
   parameter int LUT_PORT_SIZE   = 2,
   parameter int PAGE_NUM        = 8,
   parameter int ITER_MAX        = 16,
   parameter int ITER_W          = 4
) (
   input  logic                              write_clk,
   input  logic                              rstn,
   input  logic                              iter_start,
   input  logic [LUT_PORT_SIZE*BANK_NUM-1:0] data_in,
   input  logic                              data_valid,
   output logic                              data_ready,
   output logic [ENTRY_ADDR-1:0]             page_addr_ram,
   output logic [LUT_PORT_SIZE*BANK_NUM-1:0] ram_write_data_1,
   output logic                              ib_ram_we,
   output logic                              read_addr_offset,
   output logic                              load_done,
   output logic                              start_drop,
   output logic [ITER_W-1:0]                 iter_cnt,
   output logic                              busy
);

   localparam int DW = LUT_PORT_SIZE*BANK_NUM;
   localparam int PW = ENTRY_ADDR-1;

   if (MULTI_FRAME_NUM != 2 || PAGE_NUM != 2**PW || ITER_W != $clog2(ITER_MAX)) begin : g_bad_cfg
      $error("ib_lut_page_loader: inconsistent parameters");
   end

   typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;

   state_t                state_q, state_d;
   logic [PW-1:0]         page_q, page_d;
   logic [ENTRY_ADDR-1:0] addr_q, addr_d;
   logic [DW-1:0]         data_q, data_d;
   logic                  we_q, we_d;
   logic                  off_q, off_d;
   logic                  drop_q, drop_d;
   logic [ITER_W-1:0]     iter_q, iter_d;

   always_ff @(posedge write_clk) begin
      if (!rstn) begin
         state_q <= IDLE;
         page_q  <= '0;
         addr_q  <= '0;
         data_q  <= '0;
         we_q    <= 1'b0;
         off_q   <= 1'b0;
         drop_q  <= 1'b0;
         iter_q  <= '0;
      end else begin
         state_q <= state_d;
         page_q  <= page_d;
         addr_q  <= addr_d;
         data_q  <= data_d;
         we_q    <= we_d;
         off_q   <= off_d;
         drop_q  <= drop_d;
         iter_q  <= iter_d;
      end
   end

   always_comb begin
      state_d = state_q;
      page_d  = page_q;
      addr_d  = addr_q;
      data_d  = data_q;
      we_d    = 1'b0;
      off_d   = off_q;
      drop_d  = 1'b0;
      iter_d  = iter_q;
      case (state_q)
         IDLE: begin
            if (iter_start) begin
               state_d = LOAD;
               page_d  = '0;
            end
         end
         LOAD: begin
            drop_d = iter_start;
            if (data_valid) begin
               // Always target the frame the CNU is not reading.
               addr_d = {~off_q, page_q};
               data_d = data_in;
               we_d   = 1'b1;
               page_d = page_q + PW'(1);
               if (page_q == PW'(PAGE_NUM-1)) state_d = DONE;
            end
         end
         DONE: begin
            drop_d  = iter_start;
            state_d = IDLE;
            off_d   = ~off_q;
            if (iter_q != ITER_W'(ITER_MAX-1)) iter_d = iter_q + ITER_W'(1);
         end
         default: state_d = IDLE;
      endcase
   end

   assign data_ready       = (state_q == LOAD);
   assign busy             = (state_q != IDLE);
   assign load_done        = (state_q == DONE);
   assign page_addr_ram    = addr_q;
   assign ram_write_data_1 = data_q;
   assign ib_ram_we        = we_q;
   assign read_addr_offset = off_q;
   assign start_drop       = drop_q;
   assign iter_cnt         = iter_q;

endmodule
